// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the interrupt claim/complete controller.
// Holds the FSM state encoding, the coalesce counter width and a popcount helper.
package intr_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } fsm_state_t;

    localparam int COALESCE_W = 16;
    localparam logic [COALESCE_W-1:0] COALESCE_MAX = '1;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/intr_claim_ctrl_if.sv
// Bundle of the controller's source, claim and complete signals.
// slave is the controller side, master is the interrupt consumer side.
interface intr_claim_ctrl_if
    import intr_ctrl_pkg::*;
#(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
);
    logic [INTR_WIDTH-1:0] intr_in;
    logic [INTR_WIDTH-1:0] intr_enable;
    logic                  irq;
    logic                  claim_valid;
    logic                  claim_ready;
    logic [ID_WIDTH-1:0]   claim_id;
    logic                  complete_valid;
    logic [ID_WIDTH-1:0]   complete_id;
    logic                  complete_err;
    logic [COALESCE_W-1:0] coalesce_cnt;

    modport slave (
        input  intr_in, intr_enable, claim_ready, complete_valid, complete_id,
        output irq, claim_valid, claim_id, complete_err, coalesce_cnt
    );

    modport master (
        output intr_in, intr_enable, claim_ready, complete_valid, complete_id,
        input  irq, claim_valid, claim_id, complete_err, coalesce_cnt
    );

endinterface

// File: rtl/intr_prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit.
// Bit 0 has the highest priority; any is high when at least one bit is set.
module intr_prio_enc #(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic [INTR_WIDTH-1:0] req,
    output logic [ID_WIDTH-1:0]   idx,
    output logic                  any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = INTR_WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = ID_WIDTH'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_claim_ctrl.sv
// Edge-latched interrupt controller with a single-outstanding claim/complete
// handshake, complete-error pulse and a saturating count of coalesced edges.
module intr_claim_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int INTR_WIDTH = 8,
    parameter int ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INTR_WIDTH-1:0] intr_in,
    input  logic [INTR_WIDTH-1:0] intr_enable,
    output logic                  irq,
    output logic                  claim_valid,
    input  logic                  claim_ready,
    output logic [ID_WIDTH-1:0]   claim_id,
    input  logic                  complete_valid,
    input  logic [ID_WIDTH-1:0]   complete_id,
    output logic                  complete_err,
    output logic [COALESCE_W-1:0] coalesce_cnt
);

    logic [INTR_WIDTH-1:0] intr_prev_reg;
    logic [INTR_WIDTH-1:0] pending_reg;
    logic [INTR_WIDTH-1:0] pending_next;
    logic [INTR_WIDTH-1:0] rise;
    logic [INTR_WIDTH-1:0] eligible;
    logic [INTR_WIDTH-1:0] clear_mask;
    logic [INTR_WIDTH-1:0] lost;

    fsm_state_t            state_reg;
    fsm_state_t            state_next;
    logic [ID_WIDTH-1:0]   svc_id_reg;
    logic [ID_WIDTH-1:0]   svc_id_next;
    logic                  err_reg;
    logic                  err_next;
    logic [COALESCE_W-1:0] coalesce_reg;
    logic [COALESCE_W-1:0] coalesce_next;
    logic [COALESCE_W:0]   coalesce_sum;
    logic [5:0]            lost_count;

    logic [ID_WIDTH-1:0]   enc_idx;
    logic                  enc_any;
    logic                  offer;
    logic                  accept;

    assign rise     = intr_in & ~intr_prev_reg;
    assign eligible = pending_reg & intr_enable;

    intr_prio_enc #(
        .INTR_WIDTH (INTR_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) u_prio_enc (
        .req (eligible),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign offer       = (state_reg == ST_IDLE) && enc_any;
    assign accept      = offer && claim_ready;
    assign irq         = offer;
    assign claim_valid = offer;
    assign claim_id    = offer ? enc_idx : '0;

    // A rise on the bit being claimed this cycle re-arms it rather than
    // counting as a lost edge, since the claim consumes the older event.
    generate
        for (genvar gi = 0; gi < INTR_WIDTH; gi++) begin : g_bit
            assign clear_mask[gi]   = accept && (enc_idx == ID_WIDTH'(gi));
            assign pending_next[gi] = (pending_reg[gi] & ~clear_mask[gi]) | rise[gi];
            assign lost[gi]         = rise[gi] & pending_reg[gi] & ~clear_mask[gi];
        end
    endgenerate

    assign lost_count    = popcount32(32'(lost));
    assign coalesce_sum  = {1'b0, coalesce_reg} + (COALESCE_W + 1)'(lost_count);
    assign coalesce_next = coalesce_sum[COALESCE_W] ? COALESCE_MAX
                                                    : coalesce_sum[COALESCE_W-1:0];

    always_comb begin
        state_next  = state_reg;
        svc_id_next = svc_id_reg;
        err_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next  = ST_BUSY;
                    svc_id_next = enc_idx;
                end
                if (complete_valid) begin
                    err_next = 1'b1;
                end
            end
            ST_BUSY: begin
                if (complete_valid) begin
                    if (complete_id == svc_id_reg) begin
                        state_next = ST_IDLE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // intr_prev tracks intr_in during reset so a level held across release
    // is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_prev_reg <= intr_in;
            pending_reg   <= '0;
            state_reg     <= ST_IDLE;
            svc_id_reg    <= '0;
            err_reg       <= 1'b0;
            coalesce_reg  <= '0;
        end else begin
            intr_prev_reg <= intr_in;
            pending_reg   <= pending_next;
            state_reg     <= state_next;
            svc_id_reg    <= svc_id_next;
            err_reg       <= err_next;
            coalesce_reg  <= coalesce_next;
        end
    end

    assign complete_err = err_reg;
    assign coalesce_cnt = coalesce_reg;

endmodule

// File: tb/tb_intr_claim_ctrl.sv
// Directed self-checking bench for intr_claim_ctrl: claim/complete flow,
// priority, complete errors, coalescing with saturation, enables and reset.
module tb_intr_claim_ctrl;

    localparam int INTR_WIDTH = 8;
    localparam int ID_WIDTH   = 3;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    intr_claim_ctrl_if #(.INTR_WIDTH(INTR_WIDTH), .ID_WIDTH(ID_WIDTH)) bus ();

    intr_claim_ctrl #(
        .INTR_WIDTH (INTR_WIDTH),
        .ID_WIDTH   (ID_WIDTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .intr_in        (bus.intr_in),
        .intr_enable    (bus.intr_enable),
        .irq            (bus.irq),
        .claim_valid    (bus.claim_valid),
        .claim_ready    (bus.claim_ready),
        .claim_id       (bus.claim_id),
        .complete_valid (bus.complete_valid),
        .complete_id    (bus.complete_id),
        .complete_err   (bus.complete_err),
        .coalesce_cnt   (bus.coalesce_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse(input logic [7:0] v);
        bus.intr_in = v;
        tick();
        bus.intr_in = 8'h00;
        tick();
    endtask

    task automatic claim();
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
    endtask

    task automatic complete(input logic [2:0] id);
        bus.complete_valid = 1'b1;
        bus.complete_id    = id;
        tick();
        bus.complete_valid = 1'b0;
        bus.complete_id    = 3'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst                = 1'b1;
        bus.intr_in        = 8'h00;
        bus.intr_enable    = 8'hFF;
        bus.claim_ready    = 1'b0;
        bus.complete_valid = 1'b0;
        bus.complete_id    = 3'd0;
        tick();
        tick();
        chk("rst_irq", 32'(bus.irq), 32'd0);
        chk("rst_valid", 32'(bus.claim_valid), 32'd0);
        chk("rst_id", 32'(bus.claim_id), 32'd0);
        chk("rst_err", 32'(bus.complete_err), 32'd0);
        chk("rst_coal", 32'(bus.coalesce_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Single source: one-cycle latency, claim moves to BUSY
        bus.intr_in = 8'h08;
        tick();
        chk("t1_valid", 32'(bus.claim_valid), 32'd1);
        chk("t1_id", 32'(bus.claim_id), 32'd3);
        chk("t1_irq", 32'(bus.irq), 32'd1);
        claim();
        bus.intr_in = 8'h00;
        chk("t1_busy_irq", 32'(bus.irq), 32'd0);
        chk("t1_busy_valid", 32'(bus.claim_valid), 32'd0);
        complete(3'd3);
        chk("t1_done_err", 32'(bus.complete_err), 32'd0);
        chk("t1_idle_valid", 32'(bus.claim_valid), 32'd0);

        // Two sources at once: lowest index first
        pulse(8'h24);
        chk("t2_valid", 32'(bus.claim_valid), 32'd1);
        chk("t2_id", 32'(bus.claim_id), 32'd2);
        claim();
        chk("t2_busy_valid", 32'(bus.claim_valid), 32'd0);

        // Mismatched complete: error pulse, still BUSY
        complete(3'd4);
        chk("t3_err", 32'(bus.complete_err), 32'd1);
        chk("t3_busy_valid", 32'(bus.claim_valid), 32'd0);
        tick();
        chk("t3_err_clear", 32'(bus.complete_err), 32'd0);
        complete(3'd2);
        chk("t2_next_valid", 32'(bus.claim_valid), 32'd1);
        chk("t2_next_id", 32'(bus.claim_id), 32'd5);
        chk("t2_next_err", 32'(bus.complete_err), 32'd0);
        claim();
        complete(3'd5);
        chk("t2_empty_valid", 32'(bus.claim_valid), 32'd0);
        complete(3'd0);
        chk("t3_idle_err", 32'(bus.complete_err), 32'd1);
        tick();
        chk("t3_idle_err_clear", 32'(bus.complete_err), 32'd0);

        // Coalescing on an already-pending bit, then preemption by bit 0
        pulse(8'h02);
        chk("t4_id", 32'(bus.claim_id), 32'd1);
        pulse(8'h02);
        pulse(8'h02);
        pulse(8'h02);
        chk("t4_coal", 32'(bus.coalesce_cnt), 32'd3);
        pulse(8'h01);
        chk("t4_preempt_valid", 32'(bus.claim_valid), 32'd1);
        chk("t4_preempt_id", 32'(bus.claim_id), 32'd0);
        claim();
        complete(3'd0);
        chk("t4_second_id", 32'(bus.claim_id), 32'd1);
        claim();
        complete(3'd1);
        chk("t4_empty_valid", 32'(bus.claim_valid), 32'd0);
        chk("t4_coal_hold", 32'(bus.coalesce_cnt), 32'd3);

        // Rise on the bit being claimed keeps it pending, not coalesced
        pulse(8'h04);
        bus.intr_in     = 8'h04;
        bus.claim_ready = 1'b1;
        tick();
        bus.claim_ready = 1'b0;
        bus.intr_in     = 8'h00;
        chk("t21_busy_valid", 32'(bus.claim_valid), 32'd0);
        chk("t21_coal", 32'(bus.coalesce_cnt), 32'd3);
        complete(3'd2);
        chk("t21_reoffer_valid", 32'(bus.claim_valid), 32'd1);
        chk("t21_reoffer_id", 32'(bus.claim_id), 32'd2);
        claim();
        complete(3'd2);
        chk("t21_empty_valid", 32'(bus.claim_valid), 32'd0);

        // Disabled source stays latched until enabled
        bus.intr_enable = 8'hBF;
        pulse(8'h40);
        chk("t5_irq", 32'(bus.irq), 32'd0);
        chk("t5_valid", 32'(bus.claim_valid), 32'd0);
        bus.intr_enable = 8'hFF;
        tick();
        chk("t5_en_valid", 32'(bus.claim_valid), 32'd1);
        chk("t5_en_id", 32'(bus.claim_id), 32'd6);
        claim();
        complete(3'd6);

        // Rise on the in-service source is re-offered after completion
        pulse(8'h10);
        claim();
        pulse(8'h10);
        chk("t6_busy_valid", 32'(bus.claim_valid), 32'd0);
        complete(3'd4);
        chk("t6_reoffer_valid", 32'(bus.claim_valid), 32'd1);
        chk("t6_reoffer_id", 32'(bus.claim_id), 32'd4);
        chk("t6_coal", 32'(bus.coalesce_cnt), 32'd3);
        claim();
        pulse(8'h20);

        // Reset while BUSY, with a level held high across release
        rst         = 1'b1;
        bus.intr_in = 8'h80;
        tick();
        chk("t6_rst_irq", 32'(bus.irq), 32'd0);
        chk("t6_rst_valid", 32'(bus.claim_valid), 32'd0);
        chk("t6_rst_id", 32'(bus.claim_id), 32'd0);
        chk("t6_rst_err", 32'(bus.complete_err), 32'd0);
        chk("t6_rst_coal", 32'(bus.coalesce_cnt), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("t6_norise_valid", 32'(bus.claim_valid), 32'd0);
        complete(3'd4);
        chk("t6_idle_err", 32'(bus.complete_err), 32'd1);
        bus.intr_in = 8'h00;
        tick();
        pulse(8'h80);
        chk("t6_after_id", 32'(bus.claim_id), 32'd7);

        // Saturation: all sources latched and disabled, edges pile up
        rst             = 1'b1;
        bus.intr_enable = 8'h00;
        tick();
        rst = 1'b0;
        pulse(8'hFF);
        chk("sat_irq", 32'(bus.irq), 32'd0);
        chk("sat_start", 32'(bus.coalesce_cnt), 32'd0);
        repeat (8191) pulse(8'hFF);
        chk("sat_fff8", 32'(bus.coalesce_cnt), 32'h0000FFF8);
        pulse(8'h3F);
        chk("sat_fffe", 32'(bus.coalesce_cnt), 32'h0000FFFE);
        pulse(8'h03);
        chk("sat_ffff", 32'(bus.coalesce_cnt), 32'h0000FFFF);
        pulse(8'h01);
        chk("sat_hold", 32'(bus.coalesce_cnt), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
